// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] DIV_OVF_Q  = 32'h8000_0000;
  localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;

  // RV32M funct3 encodings
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring shift-subtract
// divide on a {hi, lo} double-width accumulator.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XLEN
) (
  input  logic [2*DATA_WIDTH-1:0] acc_in,
  input  logic [DATA_WIDTH-1:0]   operand,
  input  logic                    op_is_div,
  output logic [2*DATA_WIDTH-1:0] acc_out
);

  localparam int unsigned W = DATA_WIDTH;

  logic [W:0] sum;
  logic [W:0] trial;

  // Multiply: add multiplicand to hi when lo[0] set, then shift right with carry.
  // Divide: shift remainder left, subtract divisor, keep result when non-negative.
  always_comb begin
    sum   = {1'b0, acc_in[2*W-1:W]} + (acc_in[0] ? {1'b0, operand} : '0);
    trial = acc_in[2*W-1:W-1] - {1'b0, operand};
    if (op_is_div) begin
      if (!trial[W]) begin
        acc_out = {trial[W-1:0], acc_in[W-2:0], 1'b1};
      end else begin
        acc_out = {acc_in[2*W-2:0], 1'b0};
      end
    end else begin
      acc_out = {sum, acc_in[W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M sequencer: FSM, iteration counter, operand/sign registers and
// result sign fixup around the single-step datapath.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XLEN,
  parameter int unsigned CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  kill,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  input  logic [4:0]            rd_in,
  output logic                  stall,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [4:0]            rd_out
);

  localparam int unsigned W = DATA_WIDTH;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(W - 1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  op_e                  op_q, op_d;
  logic [4:0]           rd_q, rd_d, rd_out_q, rd_out_d;
  logic [2*W-1:0]       acc_q, acc_d, step_acc, prod_fix;
  logic [W-1:0]         opb_q, opb_d, result_q, result_d, fixed_res, special_res;
  logic                 neg_q, neg_d;

  op_e        op_in;
  logic       sign_a, sign_b, neg_in, div_zero, div_ovf;
  logic [W-1:0] mag_a, mag_b;

  assign op_in = op_e'(funct3);

  // Decode incoming operands: magnitudes, result-sign flag, special divides.
  always_comb begin
    sign_a   = (op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) & rs1_data[W-1];
    sign_b   = (op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) & rs2_data[W-1];
    mag_a    = sign_a ? -rs1_data : rs1_data;
    mag_b    = sign_b ? -rs2_data : rs2_data;
    unique case (op_in)
      OP_MUL, OP_MULH, OP_DIV: neg_in = sign_a ^ sign_b;
      OP_MULHSU, OP_REM:       neg_in = sign_a;
      default:                 neg_in = 1'b0;
    endcase
    div_zero = funct3[2] & (rs2_data == '0);
    div_ovf  = (op_in inside {OP_DIV, OP_REM}) & (rs1_data == MIN_NEG) & (rs2_data == '1);
    if (div_zero) begin
      special_res = funct3[1] ? rs1_data : '1;
    end else begin
      special_res = funct3[1] ? '0 : MIN_NEG;
    end
  end

  muldiv_step #(.DATA_WIDTH(W)) u_step (
    .acc_in    (acc_q),
    .operand   (opb_q),
    .op_is_div (op_q[2]),
    .acc_out   (step_acc)
  );

  // Sign fixup and word selection applied to the final iteration's output.
  always_comb begin
    prod_fix = neg_q ? -step_acc : step_acc;
    unique case (op_q)
      OP_MUL:                        fixed_res = prod_fix[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fixed_res = prod_fix[2*W-1:W];
      OP_DIV, OP_DIVU:               fixed_res = neg_q ? -step_acc[W-1:0] : step_acc[W-1:0];
      default:                       fixed_res = neg_q ? -step_acc[2*W-1:W] : step_acc[2*W-1:W];
    endcase
  end

  // Next-state, datapath register updates and stall.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    rd_d     = rd_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    stall    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !kill) begin
          stall   = 1'b1;
          op_d    = op_in;
          rd_d    = rd_in;
          acc_d   = {{W{1'b0}}, mag_a};
          opb_d   = mag_b;
          neg_d   = neg_in;
          count_d = '0;
          if (div_zero || div_ovf) begin
            result_d = special_res;
            rd_out_d = rd_in;
            state_d  = FIN;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        stall = 1'b1;
        if (kill) begin
          count_d = '0;
          state_d = IDLE;
        end else begin
          acc_d   = step_acc;
          count_d = count_q + 1'b1;
          if (count_q == LAST) begin
            result_d = fixed_res;
            rd_out_d = rd_q;
            state_d  = FIN;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_q     <= OP_MUL;
      rd_q     <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == FIN);
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Iterative controller and datapath for the RV32M extension, issued from the decode stage.
- Decode raises start with an M-type funct3, operands and rd.
- The block stalls decode while it runs a 32-step shift-add multiply or a shift-subtract divide.
- It then presents the result with a one-cycle done pulse, so the write-back path can select it over the ALU result.

Parameters:
DATA_WIDTH, 32, operand/result width (XLEN)
CNT_WIDTH, 5, iteration counter width; must equal $clog2(DATA_WIDTH)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  issue request from decode (M-type instr decoded)
kill  input  1  flush (branch/jump taken); aborts the current operation
funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_data  input  DATA_WIDTH  operand A
rs2_data  input  DATA_WIDTH  operand B
rd_in  input  5  destination register
stall  output  1  hold fetch/decode
busy  output  1  operation in flight
done  output  1  single-cycle result-valid pulse
result  output  DATA_WIDTH  final value, valid when done=1
rd_out  output  5  destination register, valid when done=1

Behaviour:
- States: IDLE, CALC, FIN.
- Reset (rst_n=0 at an edge): state=IDLE, count=0, every internal register=0, and outputs busy=0, done=0, result=0, rd_out=0. This applies even mid-CALC; the operation in flight is discarded.
- IDLE:
  - start=1 & kill=0 latches funct3, rd_in, |A| and |B| (magnitudes for signed ops, raw operands for unsigned ops) and the result-sign flags.
  - Special divide cases go directly to FIN:
    - B==0: quotient = all ones, remainder = A.
    - DIV/REM with A=0x80000000, B=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
  - All other start-accepted ops go to CALC with count=0.
  - start=0, or kill=1, keeps the block in IDLE.
- CALC:
  - One iteration per cycle: shift-add for MUL*, restoring shift-subtract for DIV*. Use a 2*DATA_WIDTH accumulator.
  - count increments each cycle; when count==DATA_WIDTH-1, go to FIN. This gives exactly 32 CALC cycles.
- FIN:
  - Apply sign fixups:
    - MUL/MULH: negate the 64-bit product when the operand signs differ.
    - MULHSU: only rs1 is signed.
    - DIV: quotient sign is signA^signB.
    - REM: remainder takes signA.
  - Select the low word for MUL, the high word for MULH/MULHSU/MULHU, the quotient for DIV/DIVU and the remainder for REM/REMU.
  - result and rd_out are registered on entry to FIN and held until the next operation completes.
  - done=1 for exactly this cycle; next state is IDLE.
- Latency: start sampled at edge N → done high in cycle N+33 for normal ops and in cycle N+1 for special divide cases.
- stall = (state==IDLE & start & ~kill) | (state==CALC). stall is 0 in FIN, so decode advances in the same cycle the result is presented.
- busy = (state != IDLE).
- kill=1 in CALC or FIN forces IDLE at the next edge with done=0 in that next cycle; if kill is sampled in FIN, done still reads 1 during that FIN cycle. kill has priority over start.
- start while busy is ignored; the instruction stays stalled in decode and is re-presented after FIN.
- Back-to-back: start in the FIN cycle is not accepted. It is accepted in the following IDLE cycle, so the minimum issue interval is 34 cycles.

Decomposition:
- Package muldiv_pkg holds:
  - the funct3 op enum (MUL..REMU);
  - the state enum (IDLE, CALC, FIN);
  - constants XLEN=32, DIV_OVF_Q=32'h80000000 and DIV_ZERO_Q='1.
- Sub-module muldiv_step, purely combinational. It performs one iteration: accumulator in, multiplicand/divisor, op_is_div → next accumulator.
- muldiv_sequencer holds the FSM, counter, operand and sign registers, and the fixup logic.

Test Plan:
- MUL 7 × -3 (0x00000007, 0xFFFFFFFD): stall high for 33 cycles (issue cycle plus 32 CALC cycles) → done in cycle N+33 with result=0xFFFFFFEB and rd_out=rd_in.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → result=0xFFFFFFFE; the same operands with MULH → 0x00000000; MULHSU → 0xFFFFFFFF.
- DIV -7/2 → result 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV x/0 with x=5 → done at N+1 with 0xFFFFFFFF; REM x/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- kill asserted at CALC count=10 → IDLE next cycle, no done pulse, stall=0. A new DIVU 9/3 issued afterwards returns 3.
- rst_n=0 mid-CALC for one cycle → busy=0, done=0, result=0. A start held high throughout is ignored while busy and accepted in the cycle after FIN.
